aes128_enc_sequencer: RTL and testbench
=======================================

# aes128_enc_sequencer

Iterative AES-128 encryption engine controller. Accepts one plaintext block and cipher key per transaction, then drives one cipher round per clock through a shared combinational round datapath: SubBytes, ShiftRows, MixColumns (bypassed in the final round) and AddRoundKey. Round keys are expanded on the fly. Sits between the host-side block interface and the encryption round modules.

## Interface
- No parameters. Only AES-128 is supported: Nk=4 and Nr=10 are fixed constants in the package.
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  plaintext/key presented
- in_ready  out  1  block can accept; high only in IDLE
- in_data  in  128  plaintext; [127:96]=w0 … [31:0]=w3, byte [31:24] of each word = row 0
- in_key  in  128  cipher key, same word/byte order
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext, same order
- busy  out  1  high in ROUND or FINAL
- abort  in  1  present only with AES_ABORT_EN

## Operation
- States:
  - IDLE → ROUND on in_valid&in_ready.
  - ROUND → FINAL when rnd==9 completes.
  - FINAL → DONE.
  - DONE → IDLE on out_valid&out_ready.
- Accept edge:
  - state_reg ← in_data ^ in_key (round 0 AddRoundKey).
  - key_reg ← in_key.
  - rcon ← 8'h01.
  - rnd ← 1.
- ROUND edge (rnd 1..9):
  - next_key = KeyExpand(key_reg, rcon): w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - state_reg ← MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_key.
  - key_reg ← next_key; rcon ← xtime(rcon); rnd ← rnd+1.
- FINAL edge (rnd 10, rcon=8'h36):
  - Same as ROUND edge, but MixColumns is bypassed.
  - out_data ← result.
- rcon sequence: 01,02,04,08,10,20,40,80,1B,36. xtime is a left shift with conditional ^8'h1B, computed in 8 bits.
- ShiftRows: row r of column c takes row r of column (c+r) mod 4.
- DONE:
  - out_valid held high; out_data held stable until the handshake.
  - in_ready low, so no new block is accepted in DONE or in the same cycle as the output handshake.
- in_data, in_key and in_valid are ignored outside IDLE.

## Timing
- Reset values:
  - State IDLE, so in_ready=1 during and after reset.
  - out_valid=0, out_data=0, busy=0.
  - rnd=0, rcon=8'h00, state_reg=0, key_reg=0.
- Latency: acceptance at edge E gives out_valid=1 after edge E+10 (9 ROUND edges, then 1 FINAL edge).
- Throughput: with out_ready tied high, one block per 12 cycles (accept, 10 rounds, output handshake).
- out_ready=0 stalls indefinitely in DONE with no change to outputs.
- Reset asserted mid-operation: all state clears immediately (asynchronous), the in-flight block is dropped, and no out_valid is produced.
- in_ready, out_valid and busy are decoded combinationally from the state register only, with no input-to-output combinational path.

## Configuration
- AES_ABORT_EN defined:
  - The abort port exists.
  - abort sampled high in ROUND, FINAL or DONE forces IDLE at the next edge: out_valid=0, out_data cleared to 0, rnd=0.
  - abort in IDLE has no effect.
  - abort has priority over the output handshake.
- AES_ABORT_EN undefined: the port and its logic are absent; behaviour is otherwise identical.

## Structure
- Package aes_pkg holds:
  - state enum {IDLE, ROUND, FINAL, DONE}
  - NR=10, RCON_INIT=8'h01
  - functions sbox(byte), sub_word, rot_word, xtime
- Sub-module aes_enc_round (combinational):
  - Inputs: state, round_key, last_round.
  - Output: the round result.
  - Contains the existing SubBytes, ShiftRows and MixColumns modules plus the final XOR.
- Key expansion is implemented in the sequencer using package functions.

## Test plan
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 → out_data 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 edges after the accept edge.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Backpressure:
  - out_ready held low 20 cycles → out_data stable, in_ready=0, busy=0.
  - in_valid pulsed during the stall is ignored.
  - Release → IDLE, in_ready=1 next cycle.
- Back-to-back: in_valid and out_ready held high with the two vectors above → both ciphertexts correct, in order, 12 cycles apart.
- Reset asserted at round 5 → out_valid=0 and in_ready=1 immediately. A fresh App. B transaction after reset yields the correct result.
- With AES_ABORT_EN: abort at round 3 → IDLE next edge, no out_valid. The next block encrypts correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 shared definitions: FSM states, cipher constants and the byte-level
// helper functions used by both the round datapath and the key expansion.
package aes_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} aes_state_e;

    localparam int         NK        = 4;
    localparam int         NR        = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed rather than tabulated: multiplicative inverse as b^254
    // (b^2 * b^4 * ... * b^128, with 0 mapping to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = b;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes128_enc_sequencer_if.sv
// Host-side block interface of the AES-128 sequencer: plaintext/key input
// handshake, ciphertext output handshake and the busy status.
interface aes128_enc_sequencer_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round: SubBytes, ShiftRows, MixColumns
// (skipped when last_round_i) and AddRoundKey. Byte (col c, row r) lives at
// bits [127-8*(4c+r) -: 8].
module aes_enc_round
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] round_key_i,
    input  logic         last_round_i,
    output logic [127:0] result_o
);
    logic [127:0] sb;
    logic [127:0] sr;
    logic [127:0] mc;

    // SubBytes and ShiftRows: row r of column c takes row r of column (c+r)%4
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int DST = 4 * c + r;
            localparam int SRC = 4 * ((c + r) % 4) + r;
            assign sb[127-8*DST -: 8] = sbox(state_i[127-8*DST -: 8]);
            assign sr[127-8*DST -: 8] = sb[127-8*SRC -: 8];
        end
    end

    // MixColumns on each column of the shifted state
    for (genvar c = 0; c < 4; c++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[127-32*c -: 8];
        assign a1 = sr[119-32*c -: 8];
        assign a2 = sr[111-32*c -: 8];
        assign a3 = sr[103-32*c -: 8];
        assign mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    assign result_o = (last_round_i ? sr : mc) ^ round_key_i;

endmodule

// File: rtl/aes128_enc_sequencer.sv
// Iterative AES-128 encryption sequencer: one round per clock through a shared
// aes_enc_round datapath, round keys expanded on the fly.
// Optional build macro AES_ABORT_EN adds an abort input that drops the
// in-flight block and returns to IDLE.
module aes128_enc_sequencer
    import aes_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
`ifdef AES_ABORT_EN
    input  logic                         abort,
`endif
    aes128_enc_sequencer_if.slave        bus
);
    aes_state_e   state_q, state_d;
    logic [3:0]   rnd_q,   rnd_d;
    logic [7:0]   rcon_q,  rcon_d;
    logic [127:0] blk_q,   blk_d;
    logic [127:0] key_q,   key_d;
    logic [127:0] out_q,   out_d;

    logic [31:0]  w0n, w1n, w2n, w3n;
    logic [127:0] next_key;
    logic [127:0] round_res;

    // Next round key from the current one and rcon
    always_comb begin
        w0n      = key_q[127:96] ^ sub_word(rot_word(key_q[31:0])) ^ {rcon_q, 24'h0};
        w1n      = key_q[95:64]  ^ w0n;
        w2n      = key_q[63:32]  ^ w1n;
        w3n      = key_q[31:0]   ^ w2n;
        next_key = {w0n, w1n, w2n, w3n};
    end

    aes_enc_round u_round (
        .state_i      (blk_q),
        .round_key_i  (next_key),
        .last_round_i (state_q == FINAL),
        .result_o     (round_res)
    );

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            rcon_q  <= '0;
            blk_q   <= '0;
            key_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            rcon_q  <= rcon_d;
            blk_q   <= blk_d;
            key_q   <= key_d;
            out_q   <= out_d;
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        rcon_d  = rcon_q;
        blk_d   = blk_q;
        key_d   = key_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = ROUND;
                    blk_d   = bus.in_data ^ bus.in_key;
                    key_d   = bus.in_key;
                    rcon_d  = RCON_INIT;
                    rnd_d   = 4'd1;
                end
            end
            ROUND: begin
                blk_d  = round_res;
                key_d  = next_key;
                rcon_d = xtime(rcon_q);
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == 4'(NR - 1)) state_d = FINAL;
            end
            FINAL: begin
                blk_d   = round_res;
                key_d   = next_key;
                rcon_d  = xtime(rcon_q);
                rnd_d   = rnd_q + 4'd1;
                out_d   = round_res;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef AES_ABORT_EN
        // Abort wins over everything, including the output handshake
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            out_d   = '0;
            rnd_d   = '0;
        end
`endif
    end

    // Handshake/status outputs depend on the state register only
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q == ROUND) || (state_q == FINAL);
        bus.out_valid = (state_q == DONE);
        bus.out_data  = out_q;
    end

endmodule

// File: tb/tb_aes128_enc_sequencer.sv
// Self-checking bench for aes128_enc_sequencer: a byte-array AES reference and
// a cycle-level handshake model are compared with the DUT every cycle.
module tb_aes128_enc_sequencer;

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes128_enc_sequencer_if bus();
`ifdef AES_ABORT_EN
    logic abort;
`endif

    aes128_enc_sequencer dut (
        .clk   (clk),
        .rst   (rst),
`ifdef AES_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [7:0] gm2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Textbook AES-128 on a 16-byte array, byte i = column i/4, row i%4
    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   k [16];
        logic [7:0]   t [16];
        logic [7:0]   tw [4];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            k[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ k[i];
        end
        rc = 8'h01;
        for (int rd = 1; rd <= 10; rd++) begin
            tw[0] = SBOX[k[13]] ^ rc;
            tw[1] = SBOX[k[14]];
            tw[2] = SBOX[k[15]];
            tw[3] = SBOX[k[12]];
            for (int i = 0; i < 4; i++)  k[i] = k[i] ^ tw[i];
            for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = SBOX[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++) begin
                if (rd < 10) begin
                    s[4*c+0] = gm2(t[4*c]) ^ gm2(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm2(t[4*c+1]) ^ gm2(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm2(t[4*c+2]) ^ gm2(t[4*c+3]) ^ t[4*c+3];
                    s[4*c+3] = gm2(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ gm2(t[4*c+3]);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
            rc = gm2(rc);
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Cycle model: ph=0 idle, 1..10 processing, 11 holding the result
    int           ph;
    logic [127:0] m_out;
    logic [127:0] m_exp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph    = 0;
            m_out = '0;
        end else begin
`ifdef AES_ABORT_EN
            if (abort && ph != 0) begin
                ph    = 0;
                m_out = '0;
            end else
`endif
            if (ph == 0) begin
                if (bus.in_valid) begin
                    m_exp = aes_ref(bus.in_key, bus.in_data);
                    ph    = 1;
                end
            end else if (ph < 11) begin
                ph++;
                if (ph == 11) m_out = m_exp;
            end else if (bus.out_ready) begin
                ph = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready",  128'(bus.in_ready),  128'(ph == 0));
        chk("busy",      128'(bus.busy),      128'(ph >= 1 && ph <= 10));
        chk("out_valid", 128'(bus.out_valid), 128'(ph == 11));
        chk("out_data",  bus.out_data,        m_out);
    end

    // All tasks start and end 1ns after a rising edge
    task automatic send(input logic [127:0] k, input logic [127:0] p);
        int n;
        n = 0;
        bus.in_key   = k;
        bus.in_data  = p;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk("send_timeout", 128'(n), 128'(0));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = rnd128();
        bus.in_key   = rnd128();
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 50) chk("out_timeout", 128'(lat), 128'(0));
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_vec(input string name, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] c);
        int lat;
        send(k, p);
        wait_out(lat);
        chk({name, "_lat"}, 128'(lat), 128'(10));
        chk({name, "_ct"}, bus.out_data, c);
        take();
        chk({name, "_ready_after"}, 128'(bus.in_ready), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        int           nacc, nout, t0;
        logic         acc;
        logic [127:0] k, p, e;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_key    = '0;
        bus.out_ready = 1'b0;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        rst = 1'b1;

        // Pin the reference model to the published vectors
        chk("ref_B", aes_ref(KB, PB), CB);
        chk("ref_C", aes_ref(KC, PC), CC);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  128'(bus.in_ready),  128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_busy",      128'(bus.busy),      128'(0));
        chk("rst_out_data",  bus.out_data,        128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        run_vec("fips_B", KB, PB, CB);
        run_vec("fips_C", KC, PC, CC);

        // Backpressure with ignored in_valid pulses
        k = rnd128();
        p = rnd128();
        e = aes_ref(k, p);
        send(k, p);
        wait_out(lat);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.in_data  = rnd128();
            bus.in_key   = rnd128();
            @(posedge clk); #1;
            chk("stall_data",  bus.out_data,         e);
            chk("stall_ready", 128'(bus.in_ready),  128'(0));
            chk("stall_busy",  128'(bus.busy),      128'(0));
        end
        bus.in_valid = 1'b0;
        take();
        chk("release_ready", 128'(bus.in_ready), 128'(1));

        // Back-to-back with out_ready and in_valid held high
        bus.in_key    = KB;
        bus.in_data   = PB;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        nacc = 0;
        nout = 0;
        t0   = 0;
        for (int cyc = 0; cyc < 60 && nout < 2; cyc++) begin
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid) begin
                chk("b2b_ct", bus.out_data, (nout == 0) ? CB : CC);
                if (nout == 0) t0 = cyc;
                else chk("b2b_gap", 128'(cyc - t0), 128'(12));
                nout++;
            end
            @(posedge clk); #1;
            if (acc) begin
                nacc++;
                if (nacc == 1) begin
                    bus.in_key  = KC;
                    bus.in_data = PC;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
        end
        chk("b2b_count", 128'(nout), 128'(2));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;

        // Randomized traffic with random idle gaps, junk input and stalls
        for (int t = 0; t < 15; t++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            k = rnd128();
            p = rnd128();
            e = aes_ref(k, p);
            send(k, p);
            bus.in_valid = 1'($urandom_range(0, 1));
            wait_out(lat);
            bus.in_valid = 1'b0;
            chk("rand_lat", 128'(lat), 128'(10));
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk); #1;
            end
            chk("rand_ct", bus.out_data, e);
            take();
        end

        // Reset in the middle of round 5
        send(rnd128(), rnd128());
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("midrst_in_ready",  128'(bus.in_ready),  128'(1));
        chk("midrst_busy",      128'(bus.busy),      128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_vec("after_rst_B", KB, PB, CB);

`ifdef AES_ABORT_EN
        // Abort during round 3
        send(rnd128(), rnd128());
        repeat (2) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_ready",     128'(bus.in_ready),  128'(1));
        chk("abort_busy",      128'(bus.busy),      128'(0));
        chk("abort_out_valid", 128'(bus.out_valid), 128'(0));
        repeat (12) begin
            @(posedge clk); #1;
        end
        chk("abort_no_out", 128'(bus.out_valid), 128'(0));
        run_vec("after_abort_C", KC, PC, CC);

        // Abort in IDLE is inert; abort in DONE beats the handshake
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle_data", bus.out_data, CC);
        send(KB, PB);
        wait_out(lat);
        abort         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        abort         = 1'b0;
        bus.out_ready = 1'b0;
        chk("abort_done_data", bus.out_data, 128'(0));
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
